// File: rtl/user_id_entry.sv
// Keypad user-ID collector: four nibbles form a 16-bit ID, a sequential table search yields the password.
// Optional lockout after three consecutive failed searches is enabled by defining ID_LOCKOUT_EN.
module user_id_entry #(
    parameter int NUM_USERS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        loadButton_s,
    input  logic [3:0]  idInput,
    input  logic        logout_s,
    output logic        userIDfoundFlag,
    output logic [15:0] PASSWORD,
    output logic [2:0]  userIndex,
    output logic        notFoundFlag,
    output logic        lockedFlag,
    output logic [2:0]  state
);

    // Strobe semantics: loadButton_s and logout_s are single-cycle pulses with no back-pressure.
    // A pulse is consumed at the rising edge where it is high only if the current state accepts
    // it; otherwise it is dropped and never remembered.

    typedef enum logic [2:0] {
        DIG0     = 3'b000,
        DIG1     = 3'b001,
        DIG2     = 3'b010,
        DIG3     = 3'b011,
        SEARCH   = 3'b100,
        FOUND    = 3'b101,
        NOTFOUND = 3'b110,
        LOCKED   = 3'b111
    } state_e;

    localparam logic [2:0] LAST_IDX = 3'(NUM_USERS - 1);

    state_e      state_q, state_d;
    logic [15:0] id_q, id_d;
    logic [15:0] pw_q, pw_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  uidx_q, uidx_d;
`ifdef ID_LOCKOUT_EN
    logic [1:0]  fail_q, fail_d;
`endif

    function automatic logic [15:0] tab_id(input logic [2:0] i);
        case (i)
            3'd0:    tab_id = 16'h1234;
            3'd1:    tab_id = 16'hBEEF;
            3'd2:    tab_id = 16'h0001;
            3'd3:    tab_id = 16'hA5A5;
            3'd4:    tab_id = 16'h4444;
            3'd5:    tab_id = 16'h5555;
            3'd6:    tab_id = 16'h6666;
            default: tab_id = 16'h7777;
        endcase
    endfunction

    function automatic logic [15:0] tab_pw(input logic [2:0] i);
        case (i)
            3'd0:    tab_pw = 16'h5678;
            3'd1:    tab_pw = 16'h0420;
            3'd2:    tab_pw = 16'hFFFF;
            3'd3:    tab_pw = 16'h3C3C;
            3'd4:    tab_pw = 16'h0004;
            3'd5:    tab_pw = 16'h0005;
            3'd6:    tab_pw = 16'h0006;
            default: tab_pw = 16'h0007;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DIG0;
            id_q    <= '0;
            pw_q    <= '0;
            idx_q   <= '0;
            uidx_q  <= '0;
`ifdef ID_LOCKOUT_EN
            fail_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pw_q    <= pw_d;
            idx_q   <= idx_d;
            uidx_q  <= uidx_d;
`ifdef ID_LOCKOUT_EN
            fail_q  <= fail_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        pw_d    = pw_q;
        idx_d   = idx_q;
        uidx_d  = uidx_q;
`ifdef ID_LOCKOUT_EN
        fail_d  = fail_q;
`endif
        case (state_q)
            DIG0: begin
                id_d = '0;
                if (loadButton_s) begin
                    id_d    = {idInput, 12'h000};
                    state_d = DIG1;
                end
            end
            DIG1: begin
                if (loadButton_s) begin
                    id_d[11:8] = idInput;
                    state_d    = DIG2;
                end
            end
            DIG2: begin
                if (loadButton_s) begin
                    id_d[7:4] = idInput;
                    state_d   = DIG3;
                end
            end
            DIG3: begin
                if (loadButton_s) begin
                    id_d[3:0] = idInput;
                    idx_d     = '0;
                    state_d   = SEARCH;
                end
            end
            SEARCH: begin
                if (id_q == tab_id(idx_q)) begin
                    pw_d    = tab_pw(idx_q);
                    uidx_d  = idx_q;
                    state_d = FOUND;
`ifdef ID_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end else if (idx_q == LAST_IDX) begin
                    state_d = NOTFOUND;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            FOUND: begin
                if (logout_s) begin
                    pw_d    = '0;
                    uidx_d  = '0;
                    state_d = DIG0;
                end
            end
            NOTFOUND: begin
`ifdef ID_LOCKOUT_EN
                fail_d  = fail_q + 2'd1;
                state_d = (fail_q == 2'd2) ? LOCKED : DIG0;
`else
                state_d = DIG0;
`endif
            end
            LOCKED: begin
`ifdef ID_LOCKOUT_EN
                state_d = LOCKED;
`else
                state_d = DIG0;
`endif
            end
            default: state_d = DIG0;
        endcase
    end

    // All outputs decode registered state only.
    assign userIDfoundFlag = (state_q == FOUND);
    assign notFoundFlag    = (state_q == NOTFOUND);
    assign PASSWORD        = pw_q;
    assign userIndex       = uidx_q;
    assign state           = state_q;
`ifdef ID_LOCKOUT_EN
    assign lockedFlag      = (state_q == LOCKED);
`else
    assign lockedFlag      = 1'b0;
`endif

endmodule

// File: tb/tb_user_id_entry.sv
// Self-checking bench for user_id_entry: directed scenarios plus randomized ID entries,
// checked against a table-lookup reference model with a fail-streak counter.
module tb_user_id_entry;

    localparam int NUM_USERS = 4;
`ifdef ID_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        loadButton_s = 1'b0;
    logic [3:0]  idInput = 4'h0;
    logic        logout_s = 1'b0;
    logic        userIDfoundFlag;
    logic [15:0] PASSWORD;
    logic [2:0]  userIndex;
    logic        notFoundFlag;
    logic        lockedFlag;
    logic [2:0]  state;

    user_id_entry #(.NUM_USERS(NUM_USERS)) dut (
        .clk             (clk),
        .rst             (rst),
        .loadButton_s    (loadButton_s),
        .idInput         (idInput),
        .logout_s        (logout_s),
        .userIDfoundFlag (userIDfoundFlag),
        .PASSWORD        (PASSWORD),
        .userIndex       (userIndex),
        .notFoundFlag    (notFoundFlag),
        .lockedFlag      (lockedFlag),
        .state           (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] exp_q[$];
    logic [15:0] ref_id[8];
    logic [15:0] ref_pw[8];
    int          model_fails = 0;
    bit          model_locked = 1'b0;
    bit          last_found = 1'b0;
    logic [15:0] last_pw = '0;
    logic [2:0]  last_idx = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lookup(input logic [15:0] id);
        for (int i = 0; i < NUM_USERS; i++)
            if (ref_id[i] == id) return i;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        loadButton_s = 1'b0;
        logout_s = 1'b0;
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_found", 32'(userIDfoundFlag), 32'd0);
        check("rst_pw", 32'(PASSWORD), 32'd0);
        check("rst_idx", 32'(userIndex), 32'd0);
        check("rst_nf", 32'(notFoundFlag), 32'd0);
        check("rst_locked", 32'(lockedFlag), 32'd0);
        rst = 1'b1;
        model_fails = 0;
        model_locked = 1'b0;
    endtask

    // driver: four nibbles, random idle gaps, logout noise that DIG states must ignore
    task automatic enter_nibbles(input logic [15:0] id);
        for (int n = 3; n >= 0; n--) begin
            repeat ($urandom_range(0, 2)) begin
                loadButton_s = 1'b0;
                logout_s = 1'($urandom_range(0, 1));
                tick();
            end
            loadButton_s = 1'b1;
            idInput = id[n*4 +: 4];
            logout_s = 1'($urandom_range(0, 1));
            tick();
        end
        loadButton_s = 1'b0;
        logout_s = 1'b0;
    endtask

    task automatic finish_search(input logic [15:0] id);
        int k;
        int lat;
        last_found = 1'b0;
        if (model_locked) begin
            repeat (3) tick();
            check("locked_state", 32'(state), 32'd7);
            check("locked_flag", 32'(lockedFlag), 32'd1);
            check("locked_found", 32'(userIDfoundFlag), 32'd0);
            return;
        end
        k = lookup(id);
        lat = (k >= 0) ? k + 1 : NUM_USERS;
        exp_q.push_back((k >= 0) ? {1'b1, 3'(k), ref_pw[k]} : 20'h0);
        check("search_entry", 32'(state), 32'd4);
        for (int c = 1; c <= lat; c++) begin
            loadButton_s = 1'($urandom_range(0, 1));
            idInput = 4'($urandom);
            logout_s = 1'($urandom_range(0, 1));
            tick();
            if (c < lat) begin
                check("search_state", 32'(state), 32'd4);
                check("search_found", 32'(userIDfoundFlag), 32'd0);
            end
        end
        logout_s = 1'b0;
        check("result", 32'({userIDfoundFlag, userIndex, PASSWORD}), 32'(exp_q.pop_front()));
        if (k >= 0) begin
            loadButton_s = 1'b0;
            check("found_state", 32'(state), 32'd5);
            check("found_nf", 32'(notFoundFlag), 32'd0);
            model_fails = 0;
            last_found = 1'b1;
            last_pw = ref_pw[k];
            last_idx = 3'(k);
        end else begin
            check("nf_pulse", 32'(notFoundFlag), 32'd1);
            check("nf_state", 32'(state), 32'd6);
            loadButton_s = 1'($urandom_range(0, 1));
            idInput = 4'($urandom);
            tick();
            loadButton_s = 1'b0;
            if (LOCK_EN && model_fails == 2) model_locked = 1'b1;
            model_fails++;
            check("nf_clear", 32'(notFoundFlag), 32'd0);
            check("post_nf_state", 32'(state), model_locked ? 32'd7 : 32'd0);
            check("post_nf_locked", 32'(lockedFlag), 32'(model_locked));
        end
    endtask

    task automatic run_id(input logic [15:0] id);
        enter_nibbles(id);
        finish_search(id);
    endtask

    // hold load high in FOUND (must be ignored), then logout, sometimes together with load
    task automatic logout_session();
        repeat ($urandom_range(2, 5)) begin
            loadButton_s = 1'b1;
            idInput = 4'($urandom);
            tick();
            check("hold_state", 32'(state), 32'd5);
            check("hold_pw", 32'(PASSWORD), 32'(last_pw));
            check("hold_idx", 32'(userIndex), 32'(last_idx));
        end
        loadButton_s = 1'($urandom_range(0, 1));
        logout_s = 1'b1;
        tick();
        loadButton_s = 1'b0;
        logout_s = 1'b0;
        check("logout_state", 32'(state), 32'd0);
        check("logout_pw", 32'(PASSWORD), 32'd0);
        check("logout_idx", 32'(userIndex), 32'd0);
        check("logout_found", 32'(userIDfoundFlag), 32'd0);
    endtask

    initial begin
        ref_id = '{16'h1234, 16'hBEEF, 16'h0001, 16'hA5A5, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
        ref_pw = '{16'h5678, 16'h0420, 16'hFFFF, 16'h3C3C, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
        rst = 1'b0;
        repeat (2) tick();
        do_reset();

        run_id(16'h1234);
        logout_session();
        run_id(16'hA5A5);
        logout_session();
        run_id(16'h4444);

        enter_nibbles(16'hBEEF);
        do_reset();
        run_id(16'hBEEF);
        logout_session();

        repeat (3) run_id(16'h9999);
        run_id(16'h1234);
        if (last_found) logout_session();
        do_reset();
        run_id(16'h1234);
        logout_session();

        for (int t = 0; t < 30; t++) begin
            logic [15:0] id;
            id = ($urandom_range(0, 2) == 0) ? 16'($urandom) : ref_id[$urandom_range(0, 7)];
            run_id(id);
            if (last_found) logout_session();
            if (model_locked && $urandom_range(0, 1) == 1) do_reset();
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/user_id_entry.md
# user_id_entry

Collects a 16-bit user ID from the keypad one 4-bit nibble at a time, then searches an internal user table one entry per clock. On a match it presents the user's 16-bit password and a found flag to the downstream access-control stage. Sits directly upstream of access control, sharing its debounced `loadButton_s` and 4-bit keypad bus. A separate logout pulse returns the block to ID entry.

## Interface
- `NUM_USERS`, default 4: number of table entries searched, from entry 0 upward. Legal range 1..8.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `loadButton_s`  in  1  debounced single-cycle load strobe (active high).
- `idInput`  in  4  keypad nibble, sampled when `loadButton_s`=1.
- `logout_s`  in  1  single-cycle logout strobe.
- `userIDfoundFlag`  out  1  high while a matched user is held.
- `PASSWORD`  out  16  password of the matched user; 0 otherwise.
- `userIndex`  out  3  table index of the matched user; 0 otherwise.
- `notFoundFlag`  out  1  one-cycle pulse when a search completes with no match.
- `lockedFlag`  out  1  high while in LOCKED.
- `state`  out  3  current FSM state encoding.

## Operation
- Fixed table, ID/PASSWORD by index:
  - 0: 1234/5678
  - 1: BEEF/0420
  - 2: 0001/FFFF
  - 3: A5A5/3C3C
  - 4: 4444/0004
  - 5: 5555/0005
  - 6: 6666/0006
  - 7: 7777/0007
  - All values are hex. Entries at index ≥ `NUM_USERS` are never compared.
- States: DIG0=000, DIG1=001, DIG2=010, DIG3=011, SEARCH=100, FOUND=101, NOTFOUND=110, LOCKED=111.
- DIG0..DIG3:
  - On `loadButton_s`=1, capture `idInput` into ID bits [15:12], [11:8], [7:4], [3:0] respectively, then advance.
  - DIG3 advances to SEARCH and clears `idx` to 0.
  - With no strobe, the state holds.
  - DIG0 clears the captured ID register.
- SEARCH:
  - Each cycle, compare the captured ID against entry `idx`.
  - On a match: go to FOUND, load `PASSWORD`, set `userIndex`=`idx`, clear `failCnt`.
  - No match and `idx`=`NUM_USERS`-1: go to NOTFOUND.
  - Otherwise `idx`+1.
  - `loadButton_s` and `logout_s` are ignored.
- FOUND:
  - `userIDfoundFlag`=1 and `PASSWORD` held stable.
  - `loadButton_s` is ignored; those strobes belong to the downstream stage.
  - On `logout_s`=1: go to DIG0 and clear `userIDfoundFlag`, `PASSWORD` and `userIndex` to 0 at the same edge.
- NOTFOUND:
  - Exactly one cycle, with `notFoundFlag`=1, then DIG0.
  - A `loadButton_s` in this cycle is dropped.
- LOCKED: see Configuration. Exited only by reset.
- Simultaneous `loadButton_s` and `logout_s`:
  - In FOUND, logout wins.
  - In DIG states, logout is ignored and the load is taken.

## Timing
- Reset (`rst`=0 at a rising edge): state=DIG0; ID register, `idx`, `failCnt` = 0; all outputs 0. Applies mid-search and in LOCKED alike.
- Let E be the edge that accepts the 4th nibble. The block is in SEARCH after E.
  - Match at entry k: FOUND visible after edge E+1+k, so `userIDfoundFlag` latency is k+1 cycles.
  - No match: NOTFOUND after edge E+`NUM_USERS`; DIG0 after E+`NUM_USERS`+1.
- All outputs are registered; none are combinational from inputs.
- `notFoundFlag` is high for exactly one cycle per failed search.

## Configuration
- `ID_LOCKOUT_EN` defined:
  - 2-bit `failCnt` increments on each NOTFOUND exit and clears on any match.
  - The NOTFOUND in which `failCnt` was already 2 (third consecutive failure) goes to LOCKED instead of DIG0.
  - LOCKED: `lockedFlag`=1; all strobes are ignored until reset.
- `ID_LOCKOUT_EN` undefined:
  - No counter; NOTFOUND always returns to DIG0.
  - `lockedFlag` is tied to 0.
  - State 111 is unreachable and decodes to DIG0.

## Test plan
- Reset, then load nibbles 1,2,3,4 → `userIDfoundFlag`=1 after 1 search cycle, `PASSWORD`=5678h, `userIndex`=0.
- Load A,5,A,5 → FOUND after 4 search cycles, `PASSWORD`=3C3Ch, `userIndex`=3. Then pulse `logout_s` → next cycle state=DIG0, `PASSWORD`=0.
- `NUM_USERS`=4, load 4,4,4,4 → no match, because entry 4 is not searched: `notFoundFlag` pulses one cycle at E+4, then DIG0.
- Assert `rst`=0 during SEARCH for the ID BEEF → all outputs 0 and DIG0 next cycle; reloading BEEF yields `PASSWORD`=0420h.
- With `ID_LOCKOUT_EN` defined, three failed IDs (9999h) → LOCKED and `lockedFlag`=1; a subsequent 1234h entry is ignored; reset clears the lock. Without the macro, the same stimulus gives three `notFoundFlag` pulses and no lock.
- Hold `loadButton_s` asserted during SEARCH and FOUND → no ID change; `PASSWORD` stays stable.
